// File: rtl/freq_duty_meter.sv
// Gated frequency and duty-cycle meter: counts rising edges and high cycles of a
// synchronized input over a fixed window, then derives duty percent with a serial divider.
module freq_duty_meter #(
   parameter logic [25:0] GATE_CYCLES = 26'd50_000_000
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        sig_in,
   output logic [25:0] freq_out,
   output logic [6:0]  duty_out,
   output logic        meas_valid,
   output logic        busy_div
);

   typedef enum logic [1:0] {GATE, DIV, DONE} state_t;

   localparam logic [25:0] CNT_SAT   = '1;
   localparam logic [25:0] GATE_LAST = GATE_CYCLES - 26'd1;

   state_t      state, state_nxt;
   logic        s1, s2, s3;
   logic        rise;
   logic [25:0] gate_cnt, edge_cnt, high_cnt, edge_lat;
   logic [25:0] edge_inc, high_inc;
   logic [32:0] dq, dq_nxt;
   logic [25:0] rem, rem_nxt;
   logic [26:0] trial;
   logic        trial_ge;
   logic [5:0]  div_cnt;
   logic        gate_last, div_last;
   logic [6:0]  duty_clamp;

   assign rise      = s2 & ~s3;
   assign gate_last = (gate_cnt == GATE_LAST);
   assign div_last  = (div_cnt == 6'd32);
   assign edge_inc  = (edge_cnt == CNT_SAT) ? edge_cnt : edge_cnt + {25'd0, rise};
   assign high_inc  = (high_cnt == CNT_SAT) ? high_cnt : high_cnt + {25'd0, s2};

   // Restoring division step: dq shifts the dividend out at the top and the
   // quotient bits in at the bottom; the remainder always stays below GATE_CYCLES.
   assign trial      = {rem, dq[32]};
   assign trial_ge   = (trial >= {1'b0, GATE_CYCLES});
   assign rem_nxt    = trial_ge ? (trial[25:0] - GATE_CYCLES) : trial[25:0];
   assign dq_nxt     = {dq[31:0], trial_ge};
   assign duty_clamp = (dq_nxt > 33'd100) ? 7'd100 : dq_nxt[6:0];

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) state <= GATE;
      else      state <= state_nxt;
   end

   // meas_valid is a single-cycle strobe with no ready: freq_out/duty_out are
   // already updated in the cycle it is high and hold until the next strobe.
   always_comb begin
      state_nxt  = state;
      meas_valid = 1'b0;
      busy_div   = 1'b0;
      case (state)
         GATE: if (gate_last) state_nxt = DIV;
         DIV: begin
            busy_div = 1'b1;
            if (div_last) state_nxt = DONE;
         end
         DONE: begin
            meas_valid = 1'b1;
            state_nxt  = GATE;
         end
         default: state_nxt = GATE;
      endcase
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         s1       <= 1'b0;
         s2       <= 1'b0;
         s3       <= 1'b0;
         gate_cnt <= '0;
         edge_cnt <= '0;
         high_cnt <= '0;
         edge_lat <= '0;
         dq       <= '0;
         rem      <= '0;
         div_cnt  <= '0;
         freq_out <= '0;
         duty_out <= '0;
      end else begin
         s1 <= sig_in;
         s2 <= s1;
         s3 <= s2;
         case (state)
            GATE: begin
               gate_cnt <= gate_cnt + 26'd1;
               edge_cnt <= edge_inc;
               high_cnt <= high_inc;
               if (gate_last) begin
                  edge_lat <= edge_inc;
                  dq       <= {7'd0, high_inc} * 33'd100;
                  rem      <= '0;
                  div_cnt  <= '0;
               end
            end
            DIV: begin
               dq      <= dq_nxt;
               rem     <= rem_nxt;
               div_cnt <= div_cnt + 6'd1;
               if (div_last) begin
                  freq_out <= edge_lat;
                  duty_out <= duty_clamp;
               end
            end
            DONE: begin
               gate_cnt <= '0;
               edge_cnt <= '0;
               high_cnt <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_freq_duty_meter.sv
// Bench for freq_duty_meter: per-cycle sample log feeds a window-level reference
// model whose results are queued and compared whenever meas_valid is seen.
module tb_freq_duty_meter;

   localparam int G   = 100;
   localparam int PER = G + 34;

   logic        clk, clr, sig_in;
   logic [25:0] freq_out;
   logic [6:0]  duty_out;
   logic        meas_valid, busy_div;

   freq_duty_meter #(.GATE_CYCLES(26'(G))) dut (
      .clk(clk), .clr(clr), .sig_in(sig_in),
      .freq_out(freq_out), .duty_out(duty_out),
      .meas_valid(meas_valid), .busy_div(busy_div)
   );

   int          checks = 0;
   int          errors = 0;
   logic [32:0] exp_q[$];
   logic        xs[$];

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, req);
      end
   endtask

   // stimulus generator
   int   mode = 1;
   int   per_p = 10, per_h = 5, ph = 0, run_left = 0;
   logic rlev = 1'b0;

   initial begin
      sig_in = 1'b1;
      forever begin
         @(negedge clk);
         case (mode)
            0: sig_in = 1'b0;
            1: sig_in = 1'b1;
            2: begin sig_in = ((ph % per_p) < per_h); ph++; end
            3: begin
               if (run_left == 0) begin
                  rlev     = ~rlev;
                  run_left = $urandom_range(2, 9);
               end
               sig_in = rlev;
               run_left--;
            end
            default: begin sig_in = busy_div && ((ph % 4) < 2); ph++; end
         endcase
      end
   end

   // reference model: sig_in sampled at clock j reaches the counters at clock j+2
   function automatic logic xv(int j);
      if (j < 1) return 1'b0;
      return xs[j-1];
   endfunction

   initial begin
      int          cyc, edges, highs, duty;
      logic        h, p;
      logic [25:0] ef;
      logic [6:0]  dt;
      cyc = 0;
      forever begin
         @(posedge clk);
         if (!clr) begin
            xs.delete();
            exp_q.delete();
            cyc = 0;
         end else begin
            cyc++;
            xs.push_back(sig_in);
            if (((cyc - 1) % PER) == G - 1) begin
               edges = 0;
               highs = 0;
               for (int j = cyc - G + 1; j <= cyc; j++) begin
                  h = xv(j - 2);
                  p = xv(j - 3);
                  if (h) highs++;
                  if (h && !p) edges++;
               end
               duty = (highs * 100) / G;
               if (duty > 100) duty = 100;
               ef = edges[25:0];
               dt = duty[6:0];
               exp_q.push_back({ef, dt});
            end
         end
      end
   end

   // monitor / scoreboard
   int pulses = 0;
   initial begin
      int          ncyc, last, busy_run;
      logic        have_last, prev_mv;
      logic [32:0] e;
      ncyc = 0; last = 0; busy_run = 0; have_last = 1'b0; prev_mv = 1'b0;
      forever begin
         @(negedge clk);
         ncyc++;
         if (!clr) begin
            busy_run  = 0;
            have_last = 1'b0;
            prev_mv   = 1'b0;
         end else begin
            if (meas_valid) begin
               pulses++;
               chk("mv_width", longint'(prev_mv), 0);
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_mv actual=1 required=0");
               end else begin
                  e = exp_q.pop_front();
                  chk("freq", longint'(freq_out), longint'(e[32:7]));
                  chk("duty", longint'(duty_out), longint'(e[6:0]));
               end
               if (have_last) chk("period", longint'(ncyc - last), PER);
               last      = ncyc;
               have_last = 1'b1;
            end
            if (busy_div) busy_run++;
            else if (busy_run != 0) begin
               chk("div_len", longint'(busy_run), 33);
               busy_run = 0;
            end
            prev_mv = meas_valid;
         end
      end
   end

   task automatic wait_pulse(input string nm);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!meas_valid && n < 300);
      if (!meas_valid) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout actual=%0d required<300", nm, n);
      end
   endtask

   task automatic set_mode(input int m, input int p, input int hi);
      mode  = m;
      per_p = p;
      per_h = hi;
      ph    = 0;
   endtask

   // main sequence
   initial begin
      int   n, k;
      logic lat_ok;
      clr = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_freq", longint'(freq_out), 0);
      chk("rst_duty", longint'(duty_out), 0);
      chk("rst_mv", longint'(meas_valid), 0);
      chk("rst_busy", longint'(busy_div), 0);
      @(negedge clk);
      #2 clr = 1'b1;

      // level held high through reset
      wait_pulse("hi_w1");
      chk("hi_w1_freq", longint'(freq_out), 1);
      chk("hi_w1_duty", longint'(duty_out), 98);
      wait_pulse("hi_w2");
      chk("hi_w2_freq", longint'(freq_out), 0);
      chk("hi_w2_duty", longint'(duty_out), 100);

      set_mode(0, 1, 0);
      wait_pulse("lo_w1");
      wait_pulse("lo_w2");
      chk("lo_freq", longint'(freq_out), 0);
      chk("lo_duty", longint'(duty_out), 0);

      set_mode(2, 10, 5);
      wait_pulse("p10_w1");
      wait_pulse("p10_w2");
      chk("p10_freq", longint'(freq_out), 10);
      chk("p10_duty", longint'(duty_out), 50);

      set_mode(2, 4, 1);
      wait_pulse("p4_w1");
      wait_pulse("p4_w2");
      chk("p4_freq", longint'(freq_out), 25);
      chk("p4_duty", longint'(duty_out), 25);
      wait_pulse("p4_w3");

      set_mode(2, 3, 1);
      wait_pulse("p3_w1");
      wait_pulse("p3_w2");

      set_mode(3, 1, 0);
      repeat (4) wait_pulse("rnd");

      set_mode(4, 1, 0);
      repeat (3) wait_pulse("divedge");

      // reset during the divider
      set_mode(2, 10, 5);
      wait_pulse("pre_rst");
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!busy_div && n < 300);
      if (!busy_div) begin
         checks++;
         errors++;
         $display("FAIL busy_timeout actual=%0d required<300", n);
      end
      k = $urandom_range(1, 30);
      repeat (k) @(negedge clk);
      #2 clr = 1'b0;
      #1;
      chk("mid_rst_freq", longint'(freq_out), 0);
      chk("mid_rst_duty", longint'(duty_out), 0);
      chk("mid_rst_mv", longint'(meas_valid), 0);
      chk("mid_rst_busy", longint'(busy_div), 0);
      repeat (3) @(negedge clk);
      #2 clr = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!meas_valid && n < 300);
      lat_ok = (n == G + 33) || (n == G + 34);
      if (!lat_ok) $display("rst_lat cycles=%0d", n);
      chk("rst_lat_ok", longint'(lat_ok), 1);
      wait_pulse("post_rst");

      repeat (5) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/freq_duty_meter.md
FREQ_DUTY_METER -- requirements
Module: freq_duty_meter

Interface
REQ-001 The module SHALL have parameter GATE_CYCLES, default 26'd50_000_000, meaning the measurement window length in clk cycles (1 s at 50 MHz); legal range 2..2^26-1.
REQ-002 clk  input  1  system clock, 50 MHz on-board oscillator; all state on its rising edge.
REQ-003 clr  input  1  reset, asynchronous and active-low; clr==0 resets all state immediately.
REQ-004 sig_in  input  1  square wave under measurement, asynchronous to clk; its frequency is below clk/4.
REQ-005 freq_out  output  26  rising edges counted in the last completed window (Hz when GATE_CYCLES = 1 s).
REQ-006 duty_out  output  7  high-time percentage of the last completed window, 0..100, truncated.
REQ-007 meas_valid  output  1  one-cycle pulse when freq_out and duty_out update.
REQ-008 busy_div  output  1  high while the duty divider runs; sig_in is ignored during this time.

Function
REQ-009 sig_in SHALL pass through a 2-flop synchronizer (s1, s2), then a history flop s3; the rising edge is s2 & ~s3.
REQ-010 FSM states SHALL be GATE, DIV and DONE; after reset the FSM is in GATE with gate_cnt=0, edge_cnt=0, high_cnt=0.
REQ-011 In GATE, each cycle SHALL increment gate_cnt, increment edge_cnt when the edge condition holds, and increment high_cnt when s2==1.
REQ-012 When gate_cnt==GATE_CYCLES-1 in GATE, that cycle's edge and high samples SHALL still be counted; the FSM then latches the final counts and moves to DIV next cycle.
REQ-013 edge_cnt and high_cnt SHALL be 26 bits and saturate at 2^26-1; they never wrap.
REQ-014 DIV SHALL compute duty = floor(high_cnt*100 / GATE_CYCLES) with a 33-bit dividend and a sequential restoring divider producing one quotient bit per cycle.
REQ-015 DIV SHALL last exactly 33 cycles, with busy_div=1 for all of them.
REQ-016 The quotient SHALL be clamped to 100 before it drives duty_out.
REQ-017 DONE SHALL last one cycle. In it the latched edge count goes to freq_out, the quotient to duty_out, and meas_valid=1.
REQ-018 Also in DONE, gate_cnt, edge_cnt and high_cnt SHALL clear; the FSM returns to GATE next cycle.
REQ-019 The window period SHALL be GATE_CYCLES+34 clk cycles.
REQ-020 freq_out and duty_out SHALL hold their values between DONE cycles.
REQ-021 meas_valid SHALL be high only in DONE.
REQ-022 Edges and high levels during DIV or DONE SHALL NOT be counted.
REQ-023 s3 SHALL keep tracking s2 in all states, so a level already high at window start does not count as an edge.
REQ-024 A sig_in pulse shorter than one clk period may be missed, and this is acceptable; no glitch filtering is required.

Reset
REQ-025 On clr==0: freq_out=0, duty_out=0, meas_valid=0, busy_div=0, s1=s2=s3=0, all counters and divider registers =0, FSM=GATE; no pending result survives.
REQ-026 After clr rises, the first window SHALL start counting on the first clk edge.
REQ-027 Reset asserted mid-window or mid-DIV SHALL discard the partial result, and the next meas_valid SHALL occur GATE_CYCLES+34 cycles after clr release.
REQ-028 Because s3 resets to 0, a sig_in held high through reset SHALL register exactly one edge in the first window.

Verification (GATE_CYCLES=100 unless stated)
REQ-029 sig_in toggling every 5 clk (period 10, 50%) -> second window: freq_out=10, duty_out=50, meas_valid one cycle wide.
REQ-030 sig_in period 4, high 1 clk -> steady state: freq_out=25, duty_out=25; meas_valid pulses spaced 134 cycles apart.
REQ-031 GATE_CYCLES=30, period 3, high 1 -> duty_out=33 (truncation), freq_out=10.
REQ-032 sig_in held high from reset -> window 1: freq_out=1, duty_out=98 (high 98 of 100 cycles); window 2: freq_out=0, duty_out=100. sig_in held low -> freq_out=0, duty_out=0.
REQ-033 clr pulsed low during DIV -> outputs immediately 0, busy_div=0, no meas_valid; next meas_valid 134 cycles after release with correct values.
REQ-034 Edges injected while busy_div=1 -> not counted: freq_out equals the edges seen in GATE only.
